// File: rtl/seg_display_ctrl.sv
// Four-digit 7-segment display controller that shows source A by default and
// source B for a hold window after each show_b pulse, using an iterative binary-to-BCD engine.
module seg_display_ctrl #(
    parameter int REFRESH_DIV = 50000,
    parameter int HOLD_CYCLES = 100000000,
    parameter int BLANK_LZ    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_a,
    input  logic [15:0] value_b,
    input  logic        show_b,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        src_sel,
    output logic        digits_valid
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES - 1);

    typedef enum logic {SHOW_A, SHOW_B} src_state_t;
    typedef enum logic [1:0] {LOAD, SHIFT, COMMIT} conv_state_t;

    logic [PW-1:0] presc;
    logic          tick;
    logic [1:0]    digit_sel;

    src_state_t    src_state;
    logic [HW-1:0] hold_cnt;

    conv_state_t   conv_state;
    logic [31:0]   sr;          // {bcd[15:0], bin[15:0]} double-dabble shift register
    logic [15:0]   bcd_adj;
    logic [3:0]    sh_cnt;
    logic [15:0]   sel_val;
    logic [15:0]   digits;      // committed BCD, ones in [3:0]

    logic [3:0]    lz;
    logic [3:0]    cur_digit;
    logic          blank_cur;

    assign tick = (presc == PRESC_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc     <= '0;
            digit_sel <= 2'd0;
        end else if (tick) begin
            presc     <= '0;
            digit_sel <= digit_sel + 2'd1;
        end else begin
            presc     <= presc + 1'b1;
        end
    end

    // Source arbitration: a show_b pulse always wins over expiry, so a pulse
    // landing on the final hold cycle keeps B on screen for a fresh window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_state <= SHOW_A;
            hold_cnt  <= '0;
            src_sel   <= 1'b0;
        end else begin
            case (src_state)
                SHOW_A: begin
                    if (show_b) begin
                        src_state <= SHOW_B;
                        hold_cnt  <= HOLD_MAX;
                        src_sel   <= 1'b1;
                    end
                end
                SHOW_B: begin
                    if (show_b) begin
                        hold_cnt <= HOLD_MAX;
                    end else if (hold_cnt == '0) begin
                        src_state <= SHOW_A;
                        src_sel   <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: begin
                    src_state <= SHOW_A;
                    src_sel   <= 1'b0;
                end
            endcase
        end
    end

    assign sel_val = src_sel ? value_b : value_a;

    always_comb begin
        bcd_adj = sr[31:16];
        for (int i = 0; i < 4; i++) begin
            if (sr[16 + 4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = sr[16 + 4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conv_state   <= LOAD;
            sr           <= '0;
            sh_cnt       <= 4'd0;
            digits       <= '0;
            digits_valid <= 1'b0;
        end else begin
            case (conv_state)
                LOAD: begin
                    sr[31:16]  <= '0;
                    sr[15:0]   <= (sel_val > 16'd9999) ? 16'd9999 : sel_val;
                    sh_cnt     <= 4'd0;
                    conv_state <= SHIFT;
                end
                SHIFT: begin
                    sr     <= {bcd_adj, sr[15:0]} << 1;
                    sh_cnt <= sh_cnt + 4'd1;
                    if (sh_cnt == 4'd15)
                        conv_state <= COMMIT;
                end
                COMMIT: begin
                    digits       <= sr[31:16];
                    digits_valid <= 1'b1;
                    conv_state   <= LOAD;
                end
                default: conv_state <= LOAD;
            endcase
        end
    end

    // Leading-zero mask: a digit is blankable when it and every higher digit are zero.
    always_comb begin
        lz[3] = (digits[15:12] == 4'd0);
        lz[2] = lz[3] && (digits[11:8] == 4'd0);
        lz[1] = lz[2] && (digits[7:4] == 4'd0);
        lz[0] = 1'b0;
        cur_digit = digits[4*digit_sel +: 4];
        blank_cur = (BLANK_LZ != 0) && lz[digit_sel];
    end

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end else if (!digits_valid) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end else begin
            an  <= ~(4'b0001 << digit_sel);
            seg <= blank_cur ? 7'b1111111 : decode(cur_digit);
        end
    end

endmodule
